// File: rtl/rect_pkg.sv
// Shared rectangle-sprite types and sizes used by the motion controllers and draw_rect.
package rect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE     = 2'd1,
    APEX     = 2'd2,
    WAIT_REL = 2'd3
  } motion_state_t;

  localparam int RECT_WIDTH  = 48;
  localparam int RECT_HEIGHT = 64;

  localparam int TICK_CNT_W = 19;
  localparam int VEL_W      = 8;

endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the sprite controllers and the renderer.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

endpackage

// File: rtl/rect_tick_gen.sv
// Motion tick generator: one-cycle tick every TICK_CYCLES clocks while enabled.
module rect_tick_gen
  import rect_pkg::*;
#(
  parameter int TICK_CYCLES = 400000
) (
  input  logic clk40MHz,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [TICK_CNT_W-1:0] cnt;

  assign tick = en && (cnt == TICK_CNT_W'(TICK_CYCLES - 1));

  // Held at zero while disabled so every enable starts a full period.
  always_ff @(posedge clk40MHz) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_CNT_W'(1);
    end
  end

endmodule

// File: rtl/rect_launch_ctl.sv
// Launch controller: rectangle rests on the floor following mouse X, a click
// throws it upward with decelerating velocity until apex or ceiling.
//
// state    | meaning
// IDLE     | on floor, xpos tracks mouse X
// RISE     | moving up, velocity decremented every tick
// APEX     | stopped at apex/ceiling, waiting for click
// WAIT_REL | click seen at apex, waiting for button release
module rect_launch_ctl
  import rect_pkg::*;
  import vga_pkg::*;
#(
  parameter int TICK_CYCLES = 400000,
  parameter int V0          = 32,
  parameter int Y_FLOOR     = VER_PIXELS - RECT_HEIGHT,
  parameter int Y_CEIL      = 0,
  parameter int X_MAX       = HOR_PIXELS - RECT_WIDTH
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        rising,
  output logic        at_apex
);

  localparam logic [11:0]      Y_FLOOR_V = 12'(Y_FLOOR);
  localparam logic [11:0]      Y_CEIL_V  = 12'(Y_CEIL);
  localparam logic [11:0]      X_MAX_V   = 12'(X_MAX);
  localparam logic [VEL_W-1:0] V0_V      = VEL_W'(V0);

  motion_state_t     state;
  logic [VEL_W-1:0]  velocity;
  logic              mouse_left_d;
  logic              click;
  logic              tick;
  logic              tick_en;
  logic signed [12:0] y_tmp;
  logic [11:0]       x_clamped;
  logic              unused_mouse_ypos;

  assign unused_mouse_ypos = ^mouse_ypos;

  assign click     = mouse_left & ~mouse_left_d;
  assign tick_en   = (state == RISE);
  assign x_clamped = (mouse_xpos > X_MAX_V) ? X_MAX_V : mouse_xpos;
  // Signed so an overshoot past the ceiling shows up as negative.
  assign y_tmp     = $signed({1'b0, ypos}) - $signed({{(13 - VEL_W){1'b0}}, velocity});

  rect_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk40MHz(clk40MHz),
    .rst     (rst),
    .en      (tick_en),
    .tick    (tick)
  );

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state        <= IDLE;
      velocity     <= '0;
      mouse_left_d <= 1'b0;
      xpos         <= '0;
      ypos         <= Y_FLOOR_V;
      rising       <= 1'b0;
      at_apex      <= 1'b0;
    end else begin
      mouse_left_d <= mouse_left;
      case (state)
        IDLE: begin
          ypos    <= Y_FLOOR_V;
          at_apex <= 1'b0;
          if (click) begin
            state    <= RISE;
            velocity <= V0_V;
            rising   <= 1'b1;
          end else begin
            xpos   <= x_clamped;
            rising <= 1'b0;
          end
        end
        RISE: begin
          if (tick) begin
            if (y_tmp <= $signed(13'(Y_CEIL))) begin
              ypos     <= Y_CEIL_V;
              velocity <= '0;
              state    <= APEX;
              rising   <= 1'b0;
              at_apex  <= 1'b1;
            end else begin
              ypos     <= y_tmp[11:0];
              velocity <= velocity - VEL_W'(1);
              if (velocity == VEL_W'(1)) begin
                state   <= APEX;
                rising  <= 1'b0;
                at_apex <= 1'b1;
              end else begin
                rising  <= 1'b1;
                at_apex <= 1'b0;
              end
            end
          end else begin
            rising  <= 1'b1;
            at_apex <= 1'b0;
          end
        end
        APEX: begin
          rising <= 1'b0;
          if (click) begin
            state   <= WAIT_REL;
            at_apex <= 1'b0;
          end else begin
            at_apex <= 1'b1;
          end
        end
        WAIT_REL: begin
          rising  <= 1'b0;
          at_apex <= 1'b0;
          if (!mouse_left) begin
            state <= IDLE;
            ypos  <= Y_FLOOR_V;
          end
        end
        default: begin
          state    <= IDLE;
          velocity <= '0;
          xpos     <= '0;
          ypos     <= Y_FLOOR_V;
          rising   <= 1'b0;
          at_apex  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_launch_ctl.sv
// Directed bench for rect_launch_ctl with a short tick period.
module tb_rect_launch_ctl;

  logic        clk40MHz = 1'b0;
  logic        rst;
  logic        mouse_left;
  logic        mouse_left2;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos, ypos, xpos2, ypos2;
  logic        rising, at_apex, rising2, at_apex2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk40MHz = ~clk40MHz;

  rect_launch_ctl #(.TICK_CYCLES(4), .V0(32)) dut1 (
    .clk40MHz  (clk40MHz),
    .rst       (rst),
    .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .xpos      (xpos),
    .ypos      (ypos),
    .rising    (rising),
    .at_apex   (at_apex)
  );

  rect_launch_ctl #(.TICK_CYCLES(4), .V0(40)) dut2 (
    .clk40MHz  (clk40MHz),
    .rst       (rst),
    .mouse_left(mouse_left2),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .xpos      (xpos2),
    .ypos      (ypos2),
    .rising    (rising2),
    .at_apex   (at_apex2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk40MHz);
  endtask

  initial begin
    int yexp;
    int vexp;

    rst         = 1'b1;
    mouse_left  = 1'b0;
    mouse_left2 = 1'b0;
    mouse_xpos  = 12'd0;
    mouse_ypos  = 12'd0;
    cyc(3);
    rst = 1'b0;
    chk("reset_xpos", 32'(xpos), 0);
    chk("reset_ypos", 32'(ypos), 536);
    chk("reset_rising", 32'(rising), 0);
    chk("reset_at_apex", 32'(at_apex), 0);
    chk("reset_ypos2", 32'(ypos2), 536);

    // IDLE tracking and X clamp
    mouse_xpos = 12'd100; cyc(1);
    chk("track_100", 32'(xpos), 100);
    mouse_xpos = 12'd790; cyc(1);
    chk("clamp_790", 32'(xpos), 752);
    mouse_xpos = 12'd752; cyc(1);
    chk("edge_752", 32'(xpos), 752);
    mouse_xpos = 12'd200; cyc(1);
    chk("track_200", 32'(xpos), 200);

    // Launch with button held through RISE plus extra clicks
    mouse_left = 1'b1; cyc(1);
    chk("launch_rising", 32'(rising), 1);
    chk("launch_ypos", 32'(ypos), 536);
    mouse_xpos = 12'd500;
    yexp = 536;
    vexp = 32;
    for (int k = 1; k <= 32; k++) begin
      if (k == 5 || k == 12) mouse_left = 1'b0;
      if (k == 6 || k == 13) mouse_left = 1'b1;
      cyc(3);
      chk("pre_tick_ypos", 32'(ypos), 32'(yexp));
      cyc(1);
      yexp = yexp - vexp;
      vexp = vexp - 1;
      chk("tick_ypos", 32'(ypos), 32'(yexp));
      chk("tick_xpos", 32'(xpos), 200);
      chk("tick_rising", 32'(rising), (k < 32) ? 32'd1 : 32'd0);
      chk("tick_at_apex", 32'(at_apex), (k == 32) ? 32'd1 : 32'd0);
    end
    chk("apex_ypos8", 32'(ypos), 8);

    // APEX click, hold, release
    mouse_left = 1'b0; cyc(2);
    chk("apex_hold_flag", 32'(at_apex), 1);
    chk("apex_hold_ypos", 32'(ypos), 8);
    mouse_left = 1'b1; cyc(1);
    chk("waitrel_at_apex", 32'(at_apex), 0);
    chk("waitrel_rising", 32'(rising), 0);
    cyc(10);
    chk("waitrel_ypos", 32'(ypos), 8);
    mouse_left = 1'b0; cyc(1);
    chk("release_ypos", 32'(ypos), 536);
    cyc(1);
    chk("release_xpos", 32'(xpos), 500);
    chk("release_rising", 32'(rising), 0);

    // Ceiling clamp with V0=40
    mouse_left2 = 1'b1; cyc(1);
    chk("ceil_launch_rising", 32'(rising2), 1);
    yexp = 536;
    vexp = 40;
    for (int k = 1; k <= 17; k++) begin
      cyc(4);
      if (yexp - vexp <= 0) yexp = 0;
      else yexp = yexp - vexp;
      vexp = vexp - 1;
      chk("ceil_ypos", 32'(ypos2), 32'(yexp));
      chk("ceil_at_apex", 32'(at_apex2), (k == 17) ? 32'd1 : 32'd0);
      if (k == 16) chk("ceil_tick16", 32'(ypos2), 16);
    end
    chk("ceil_final", 32'(ypos2), 0);
    chk("ceil_rising_off", 32'(rising2), 0);

    // Reset mid-RISE at tick 10, then relaunch
    mouse_left = 1'b1; cyc(1);
    yexp = 536;
    vexp = 32;
    for (int k = 1; k <= 10; k++) begin
      cyc(4);
      yexp = yexp - vexp;
      vexp = vexp - 1;
    end
    chk("pre_rst_ypos", 32'(ypos), 32'(yexp));
    rst = 1'b1; cyc(1);
    chk("rst_ypos", 32'(ypos), 536);
    chk("rst_rising", 32'(rising), 0);
    chk("rst_xpos", 32'(xpos), 0);
    chk("rst_tick_cnt", 32'(dut1.u_tick.cnt), 0);
    rst = 1'b0;
    mouse_left = 1'b0; cyc(1);
    mouse_left = 1'b1; cyc(1);
    chk("relaunch_rising", 32'(rising), 1);
    cyc(4);
    chk("relaunch_tick1", 32'(ypos), 504);
    cyc(4);
    chk("relaunch_tick2", 32'(ypos), 473);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
